// File: rtl/spi_adc_capture_if.sv
// Serial link between the capture block and the ADC(s): shared CS/SCLK and
// one data line per channel.
interface spi_adc_capture_if #(
  parameter int NCH = 1
);
  logic           adcs;
  logic           adsclk;
  logic [NCH-1:0] addatain;

  modport master (output adcs, output adsclk, input addatain);
  modport slave  (input adcs, input adsclk, output addatain);
endinterface

// File: rtl/spi_adc_capture.sv
// SPI ADC capture: frames a conversion with CS, clocks LEAD_BITS + DATA_W bits
// on SCLK and loads all channels into addata at once.
//
// state | meaning
// IDLE  | CS high, waiting for a start request or continuous mode
// CSL   | CS low setup before the first SCLK
// LEAD  | leading bits clocked and discarded
// SHIFT | result bits shifted in MSB first
// DONE  | results published, conversion counted
// CSH   | CS high quiet time before the next decision
module spi_adc_capture #(
  parameter int DATA_W    = 16,
  parameter int NCH       = 1,
  parameter int LEAD_BITS = 1,
  parameter int CSL_TICKS = 4,
  parameter int CSH_TICKS = 3
) (
  input  logic                  userclk,
  input  logic                  rst_n,
  input  logic                  adclken,
  input  logic                  mode,
  input  logic                  start,
  spi_adc_capture_if.master     bus,
  output logic [NCH*DATA_W-1:0] addata,
  output logic                  addata_valid,
  output logic                  busy,
  output logic [15:0]           smp_cnt
);

  localparam int TICK_MAX = (CSL_TICKS > CSH_TICKS) ? CSL_TICKS : CSH_TICKS;
  localparam int BIT_MAX  = (LEAD_BITS > DATA_W) ? LEAD_BITS : DATA_W;
  localparam int CNT_W    = (TICK_MAX < 2) ? 1 : $clog2(TICK_MAX);
  localparam int BIT_W    = $clog2(BIT_MAX);

  generate
    if (CSL_TICKS < 1 || CSH_TICKS < 1 || DATA_W < 2) begin : g_bad_param
      $error("spi_adc_capture: CSL_TICKS and CSH_TICKS must be >= 1, DATA_W >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, CSL, LEAD, SHIFT, DONE, CSH} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           tick_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic                       phase;
  logic                       pending;
  logic [NCH-1:0][DATA_W-1:0] sr;

  always_ff @(posedge userclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      phase        <= 1'b0;
      pending      <= 1'b0;
      sr           <= '0;
      addata       <= '0;
      addata_valid <= 1'b0;
      busy         <= 1'b0;
      smp_cnt      <= '0;
      bus.adcs     <= 1'b1;
      bus.adsclk   <= 1'b1;
    end else begin
      addata_valid <= 1'b0;
      // start is latched every cycle in IDLE, not just on ticks
      if (state == IDLE && start)
        pending <= 1'b1;
      if (adclken) begin
        case (state)
          IDLE: begin
            if (mode || pending) begin
              state    <= CSL;
              tick_cnt <= CNT_W'(CSL_TICKS - 1);
              pending  <= 1'b0;
              busy     <= 1'b1;
              bus.adcs <= 1'b0;
            end
          end
          CSL: begin
            if (tick_cnt == '0) begin
              phase      <= 1'b0;
              bus.adsclk <= 1'b0;
              if (LEAD_BITS > 0) begin
                state   <= LEAD;
                bit_cnt <= BIT_W'(LEAD_BITS - 1);
              end else begin
                state   <= SHIFT;
                bit_cnt <= BIT_W'(DATA_W - 1);
              end
            end else begin
              tick_cnt <= tick_cnt - 1'b1;
            end
          end
          LEAD, SHIFT: begin
            if (!phase) begin
              // rising SCLK edge doubles as the sample point
              phase      <= 1'b1;
              bus.adsclk <= 1'b1;
              if (state == SHIFT)
                for (int k = 0; k < NCH; k++)
                  sr[k] <= {sr[k][DATA_W-2:0], bus.addatain[k]};
            end else if (bit_cnt == '0) begin
              if (state == LEAD) begin
                state      <= SHIFT;
                bit_cnt    <= BIT_W'(DATA_W - 1);
                phase      <= 1'b0;
                bus.adsclk <= 1'b0;
              end else begin
                state    <= DONE;
                bus.adcs <= 1'b1;
              end
            end else begin
              bit_cnt    <= bit_cnt - 1'b1;
              phase      <= 1'b0;
              bus.adsclk <= 1'b0;
            end
          end
          DONE: begin
            addata       <= sr;
            addata_valid <= 1'b1;
            smp_cnt      <= smp_cnt + 16'd1;
            state        <= CSH;
            tick_cnt     <= CNT_W'(CSH_TICKS - 1);
          end
          CSH: begin
            if (tick_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
